// File: rtl/secure_memory_arbiter_pkg.sv
// secure_memory_arbiter_pkg: shared lifecycle encodings, arbiter
// state enum and default read timeout for the secure memory arbiter.
package secure_memory_arbiter_pkg;

  localparam logic [2:0] LC_RAW    = 3'b000;
  localparam logic [2:0] LC_TEST   = 3'b001;
  localparam logic [2:0] LC_DEV    = 3'b010;
  localparam logic [2:0] LC_PROD   = 3'b011;
  localparam logic [2:0] LC_LOCKED = 3'b100;

  localparam int RD_TIMEOUT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } arb_state_t;

endpackage

// File: rtl/secure_memory_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first set req bit at or
// above rr_ptr with wrap. Ports: req, rr_ptr in; grant (one-hot),
// grant_idx, grant_any out.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secure_memory_arbiter.sv
// secure_memory_arbiter: round-robin sharing of the single-port secure
// key/ID memory with per-entry write locks and lifecycle write lockout.
// Ports: req_valid/req_we/req_addr/req_wdata in, req_ready out;
// rsp_valid/rsp_err/rsp_rdata out; wr_lock_mask, lc_state in;
// memory side rd_en/wr_en/addr/wrData out, rdData/rdData_valid in.
// Option: MEM_ARB_RD_TIMEOUT_EN enables the WAIT_RD timeout counter.
module secure_memory_arbiter
  import secure_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 256,
  parameter int LENGTH     = 16,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT,
  localparam int AW        = $clog2(LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_REQ-1:0]       rsp_err,
  output logic [WIDTH-1:0]         rsp_rdata,
  input  logic [LENGTH-1:0]        wr_lock_mask,
  input  logic [2:0]               lc_state,
  output logic                     rd_en,
  output logic                     wr_en,
  output logic [AW-1:0]            addr,
  output logic [WIDTH-1:0]         wrData,
  input  logic [WIDTH-1:0]         rdData,
  input  logic                     rdData_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW:0] LEN_W = (AW+1)'(LENGTH);

  arb_state_t state_q, state_d;

  logic [IW-1:0]      g_q;
  logic [IW-1:0]      rr_ptr_q;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               err_q;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               addr_ok;
  logic               wr_blocked;
  logic               deny;
  logic               tmo_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Out-of-range entries (non-power-of-2 LENGTH) never reach memory.
  assign addr_ok    = {1'b0, addr_q} < LEN_W;
  assign wr_blocked = (lc_state == LC_LOCKED)
                    || (addr_ok && wr_lock_mask[addr_q]);
  assign deny       = !addr_ok || (we_q && wr_blocked);

`ifdef MEM_ARB_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = !rdData_valid && (tmo_q == TW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == WAIT_RD) begin
      tmo_q <= tmo_q + TW'(1);
    end else begin
      tmo_q <= '0;
    end
  end
`else
  // Constant low; RD_TIMEOUT only matters with the timeout built in.
  assign tmo_hit = 1'b0 & (RD_TIMEOUT > 0);
`endif

  assign addr      = addr_q;
  assign wrData    = wdata_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = '0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && rst_n) begin
          req_ready = grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (deny) begin
          state_d = RESP;
        end else if (we_q) begin
          wr_en   = 1'b1;
          state_d = RESP;
        end else begin
          rd_en   = 1'b1;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rdData_valid || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << g_q;
        rsp_err   = err_q ? rsp_valid : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            g_q     <= grant_idx;
            we_q    <= req_we[grant_idx];
            addr_q  <= req_addr[grant_idx*AW +: AW];
            wdata_q <= req_wdata[grant_idx*WIDTH +: WIDTH];
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: err_q <= deny;
        WAIT_RD: begin
          if (rdData_valid) begin
            rdata_q <= rdData;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        RESP: begin
          rr_ptr_q <= (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_memory_arbiter.sv
// tb_secure_memory_arbiter: directed scoreboard bench for the
// secure memory arbiter with a zero-wait memory model.
module tb_secure_memory_arbiter;
  import secure_memory_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int W  = 256;
  localparam int L  = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_err;
  logic [W-1:0]   rsp_rdata;
  logic [L-1:0]   wr_lock_mask;
  logic [2:0]     lc_state;
  logic           rd_en;
  logic           wr_en;
  logic [AW-1:0]  addr;
  logic [W-1:0]   wrData;
  logic [W-1:0]   rdData;
  logic           rdData_valid;

  secure_memory_arbiter #(
    .NUM_REQ    (N),
    .WIDTH      (W),
    .LENGTH     (L),
    .RD_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .wr_lock_mask (wr_lock_mask),
    .lc_state     (lc_state),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wrData       (wrData),
    .rdData       (rdData),
    .rdData_valid (rdData_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       err;
    logic [W-1:0] rd;
    logic       is_rd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   grant_log[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   wr_seen = 0;
  bit   mem_silent = 0;

  logic [W-1:0] mem [L];
  logic [W-1:0] A5, M0, D0, D1, D2, D3, D4, D5, D6, DX;

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait memory: data and valid one cycle after rd_en.
  always @(posedge clk) begin
    if (!rst_n) begin
      rdData_valid <= 1'b0;
      rdData       <= '0;
      mem[3]       <= {32{8'hA5}};
      mem[0]       <= {8{32'h0BAD_F00D}};
    end else begin
      rdData_valid <= rd_en && !mem_silent;
      rdData       <= mem[addr];
      if (wr_en) mem[addr] <= wrData;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) wr_seen++;
    if (rst_n && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: rsp_valid=%b, none pending",
                 rsp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", W'(rsp_valid), W'(1) << e.idx);
        chk("rsp_err", W'(rsp_err),
            e.err ? (W'(1) << e.idx) : W'(0));
        chk("rsp_cycle", W'(cyc), W'(e.cyc));
        if (e.is_rd) chk("rsp_rdata", rsp_rdata, e.rd);
      end
    end
  end

  task automatic issue(input int i, input logic we,
                       input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic e_err, input logic [W-1:0] e_rd,
                       input int lat, input bit push);
    int   n;
    exp_t x;
    n = 0;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W] = d;
    req_valid[i] = 1'b1;
    @(negedge clk);
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL grant_timeout: req %0d not accepted, want accept", i);
    end else begin
      grant_log.push_back(i);
      if (push) begin
        x.idx   = i;
        x.err   = e_err;
        x.rd    = e_rd;
        x.is_rd = !we;
        x.cyc   = cyc + lat;
        exp_q.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout: %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t, want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    A5 = {32{8'hA5}};
    M0 = {8{32'h0BAD_F00D}};
    D0 = {8{32'hD0D0_0000}};
    D1 = {8{32'hD1D1_0001}};
    D2 = {8{32'hD2D2_0002}};
    D3 = {8{32'hD3D3_0003}};
    D4 = {8{32'hD4D4_0004}};
    D5 = {8{32'hD5D5_0005}};
    D6 = {8{32'hD6D6_0006}};
    DX = {8{32'hDEAD_BEEF}};
    rst_n        = 1'b0;
    req_valid    = '1;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    wr_lock_mask = '0;
    lc_state     = LC_PROD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", W'({req_ready, rsp_valid, rsp_err, rd_en, wr_en, addr}),
        '0);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_wrdata", wrData, '0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // both requesters writing back-to-back
    grant_log.delete();
    fork
      begin
        issue(0, 1'b1, 4'd5, D0, 1'b0, '0, 2, 1'b1);
        issue(0, 1'b1, 4'd6, D1, 1'b0, '0, 2, 1'b1);
      end
      begin
        issue(1, 1'b1, 4'd7, D2, 1'b0, '0, 2, 1'b1);
        issue(1, 1'b1, 4'd8, D3, 1'b0, '0, 2, 1'b1);
      end
    join
    drain();
    chk("rr_cnt", W'(grant_log.size()), W'(4));
    if (grant_log.size() == 4) begin
      chk("rr_g0", W'(grant_log[0]), W'(0));
      chk("rr_g1", W'(grant_log[1]), W'(1));
      chk("rr_g2", W'(grant_log[2]), W'(0));
      chk("rr_g3", W'(grant_log[3]), W'(1));
    end

    // single read of preloaded entry 3
    issue(0, 1'b0, 4'd3, '0, 1'b0, A5, 3, 1'b1);
    chk("rd_strobe", W'({rd_en, wr_en, addr}), W'({1'b1, 1'b0, 4'd3}));
    drain();
    issue(1, 1'b0, 4'd7, '0, 1'b0, D2, 3, 1'b1);
    drain();
    issue(0, 1'b0, 4'd6, '0, 1'b0, D1, 3, 1'b1);
    drain();

    // per-entry write lock
    wr_lock_mask = 16'h0010;
    wr_seen = 0;
    issue(1, 1'b1, 4'd4, DX, 1'b1, '0, 2, 1'b1);
    drain();
    chk("lock_no_wr", W'(wr_seen), W'(0));
    issue(0, 1'b1, 4'd9, D4, 1'b0, '0, 2, 1'b1);
    drain();
    chk("unlocked_wr", W'(wr_seen), W'(1));
    wr_lock_mask = '0;
    issue(1, 1'b0, 4'd9, '0, 1'b0, D4, 3, 1'b1);
    drain();

    // lifecycle lockout blocks writes only
    lc_state = LC_LOCKED;
    wr_seen = 0;
    issue(1, 1'b1, 4'd0, DX, 1'b1, '0, 2, 1'b1);
    drain();
    issue(0, 1'b0, 4'd0, '0, 1'b0, M0, 3, 1'b1);
    drain();
    chk("lc_no_wr", W'(wr_seen), W'(0));
    lc_state = LC_PROD;

    // reset while waiting for read data
    mem_silent = 1;
    issue(1, 1'b0, 4'd2, '0, 1'b0, '0, 3, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ctl",
        W'({req_ready, rsp_valid, rsp_err, rd_en, wr_en, addr}), '0);
    chk("abort_rdata", rsp_rdata, '0);
    chk("abort_wrdata", wrData, '0);
    rst_n = 1'b1;
    mem_silent = 0;
    repeat (6) @(posedge clk);
    #1;
    grant_log.delete();
    fork
      issue(0, 1'b1, 4'd10, D5, 1'b0, '0, 2, 1'b1);
      issue(1, 1'b1, 4'd11, D6, 1'b0, '0, 2, 1'b1);
    join
    drain();
    chk("post_rst_g0", W'(grant_log.size() > 0 ? grant_log[0] : -1), W'(0));

`ifdef MEM_ARB_RD_TIMEOUT_EN
    mem_silent = 1;
    issue(0, 1'b0, 4'd2, '0, 1'b1, '0, 2 + TO, 1'b1);
    drain();
    mem_silent = 0;
    issue(1, 1'b0, 4'd3, '0, 1'b0, A5, 3, 1'b1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/secure_memory_arbiter.md
# secure_memory_arbiter

Round-robin arbiter that shares the single-port secure key/ID memory (256-bit × 16 entries) between several masters, such as secure boot control, lifecycle protection and a future debug/JTAG agent. It sits between those masters and the memory's rd_en/wr_en/addr/wrData/rdData/rdData_valid port. It serialises one access at a time and enforces per-entry write locks and a lifecycle-wide write lockout. It also returns a per-requester response with a read-timeout error.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- WIDTH, 256, memory data width
- LENGTH, 16, memory entries; AW = $clog2(LENGTH)
- RD_TIMEOUT, 8, max cycles to wait for rdData_valid (used only with timeout enabled)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  access request per requester, held until req_ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot single-cycle completion pulse
- rsp_err  out  NUM_REQ  error qualifier, valid with rsp_valid
- rsp_rdata  out  WIDTH  read data, valid with rsp_valid of a read
- wr_lock_mask  in  LENGTH  bit k = 1 write-protects entry k
- lc_state  in  3  lifecycle state; LC_LOCKED blocks all writes
- rd_en, wr_en  out  1  memory strobes
- addr  out  AW  memory address
- wrData  out  WIDTH  memory write data
- rdData  in  WIDTH  memory read data
- rdData_valid  in  1  memory read-data qualifier

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: if any req_valid, grant the first valid requester searching from rr_ptr upward with wrap.
  - Pulse req_ready[g] combinationally in that cycle.
  - Register g, we, addr and wdata, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (1 cycle), write, denied: a write is denied if wr_lock_mask[addr]=1 or lc_state==LC_LOCKED.
  - No strobe is driven.
  - Set err=1 and go to RESP.
- ISSUE, write, allowed: assert wr_en for 1 cycle with addr/wrData, then go to RESP with err=0.
- ISSUE, read: assert rd_en for 1 cycle, then go to WAIT_RD.
- WAIT_RD: when rdData_valid=1, capture rdData into rsp_rdata and go to RESP with err=0.
- RESP (1 cycle): assert rsp_valid[g] and rsp_err[g]=err.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - Go to IDLE.
- Fairness: a requester holding req_valid waits at most NUM_REQ-1 other transactions before it is granted.
- rdData_valid seen outside WAIT_RD is ignored.
- wr_lock_mask and lc_state are sampled in ISSUE, not at grant.
- Addresses ≥ LENGTH (non-power-of-2 LENGTH only) are treated as denied writes or err reads, with no strobe issued.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rd_en=0, wr_en=0, addr=0, wrData=0. Internally rr_ptr=0 and state=IDLE.
- Request accepted in cycle T means the strobe is asserted in T+1.
- Write latency: rsp_valid in T+2.
- Read latency: if rdData_valid arrives in cycle X, rsp_valid is in X+1. With a zero-wait memory, rdData_valid arrives in T+2 and rsp_valid in T+3.
- Throughput: at most one transaction in flight. The next grant is possible in the cycle after RESP.
- Reset asserted in any state aborts the transaction in the next clock edge. No strobe or response is emitted, and the requester must reissue.
- Simultaneous requests from all requesters after reset are served in order 0, 1, …, NUM_REQ-1.

## Configuration
- MEM_ARB_RD_TIMEOUT_EN defined:
  - WAIT_RD counts cycles.
  - If rdData_valid has not arrived after RD_TIMEOUT cycles, go to RESP with err=1 and rsp_rdata=0.
  - A late rdData_valid afterwards is ignored.
- MEM_ARB_RD_TIMEOUT_EN undefined: there is no counter, and WAIT_RD waits indefinitely.

## Structure
- The shared package holds:
  - lifecycle state constants (LC_LOCKED = 3'b100 and the other lc encodings);
  - the arbiter state enum (arb_state_t);
  - the default RD_TIMEOUT.
- One sub-module, rr_arbiter: parameterised NUM_REQ, inputs req vector and rr_ptr, output one-hot grant plus index. It is combinational and reusable for a later crypto-engine scheduler.

## Test plan
- Single read, zero-wait memory, entry 3 preloaded with 0xA5…A5: requester 0 reads addr 3.
  - req_ready[0] in T, rd_en with addr=3 in T+1.
  - rsp_valid[0] with rdata=0xA5…A5 and err=0 in T+3.
- Both requesters writing every cycle: grants alternate 0, 1, 0, 1, and each transaction completes within 3 cycles.
- wr_lock_mask=16'h0010, requester 1 writes addr 4: wr_en never asserted; rsp_valid[1] with rsp_err[1]=1 in T+2.
- lc_state=LC_LOCKED, write to addr 0: denied with err=1. A read of addr 0 in the same state succeeds with err=0.
- With MEM_ARB_RD_TIMEOUT_EN and RD_TIMEOUT=8, the memory never returns rdData_valid: rsp_valid with err=1 and rdata=0, 8 cycles after entering WAIT_RD. The next request is then granted normally.
- rst_n driven low during WAIT_RD: all outputs are 0 in the next cycle, no rsp_valid follows, and the first grant after reset goes to requester 0.
